// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and synchronous flush. Define FIFO_FWFT_EN for fall-through reads.
module param_sync_fifo #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 64,
   parameter int AF_MARGIN = 4,
   parameter int AE_MARGIN = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_valid,
   output logic                   empty,
   output logic                   full,
   output logic                   almost_empty,
   output logic                   almost_full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(DEPTH - AF_MARGIN);
   localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_MARGIN);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              empty_q, full_q, aempty_q, afull_q;
   logic              ovf_q, ovf_d, unf_q, unf_d;
   logic              wr_acc, rd_acc;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch can be inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      wr_acc   = 1'b0;
      rd_acc   = 1'b0;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         wr_acc = wr_en && !full_q;
         rd_acc = rd_en && !empty_q;
         if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
         // A write stalled behind a same-cycle pop at full is back-pressure, not an error.
         if (wr_en && full_q && !rd_en) ovf_d = 1'b1;
         if (rd_en && empty_q)          unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         aempty_q <= 1'b1;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         empty_q  <= (cnt_d == '0);
         full_q   <= (cnt_d == FULL_LVL);
         aempty_q <= (cnt_d <= AE_LVL);
         afull_q  <= (cnt_d >= AF_LVL);
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // NOTE: the storage array is deliberately left without reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr_q] <= wr_data;
   end

`ifdef FIFO_FWFT_EN
   assign rd_data  = mem[rd_ptr_q];
   assign rd_valid = !empty_q;
`else
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) rd_data_q <= mem[rd_ptr_q];
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif

   assign empty        = empty_q;
   assign full         = full_q;
   assign almost_empty = aempty_q;
   assign almost_full  = afull_q;
   assign count        = cnt_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule
